// File: rtl/csa_share_sched.sv
// Nibble-serial add/sub engine: one 4-bit carry-select slice shared by two
// requesters under round-robin arbitration, with a registered inter-nibble carry.

module csa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] sum0;
  logic [4:0] sum1;

  // Both carry-in cases are computed up front; cin only picks one.
  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + 5'd1;
  assign s    = cin ? sum1[3:0] : sum0[3:0];
  assign cout = cin ? sum1[4]   : sum0[4];
endmodule

module csa_share_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_ovf,
  output logic             res_id,
  output logic             busy,
  output logic [1:0]       fsm_state
);
  // Handshake: a requester transfers on a rising edge where its valid and
  // ready are both high; ready only ever rises in IDLE for the granted side.
  // The result transfers on an edge where res_valid and res_ready are high.

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic              id_q;
  logic              ovf_q;
  logic              prio_q;
  logic [IDXW-1:0]   idx_q;

  logic              grant;
  logic              accept;
  logic              last_nib;
  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [3:0]        s_nib;
  logic              c_nib;
  logic [WIDTH-1:0]  sel_a;
  logic [WIDTH-1:0]  sel_b;
  logic              sel_sub;

  assign last_nib = (idx_q == IDXW'(NIB - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last_nib)  state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output logic: arbitration and status flags
  always_comb begin
    grant      = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = 1'b0;
    res_valid  = 1'b0;
    case (state)
      IDLE: begin
        grant      = (req0_valid && req1_valid) ? prio_q : req1_valid;
        accept     = req0_valid || req1_valid;
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
      end
      RUN: begin
        busy = 1'b1;
      end
      DONE: begin
        busy      = 1'b1;
        res_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign fsm_state = state;

  // Operand selection for the granted requester
  always_comb begin
    sel_a   = grant ? req1_a   : req0_a;
    sel_b   = grant ? req1_b   : req0_b;
    sel_sub = grant ? req1_sub : req0_sub;
  end

  // Current nibble of each latched operand
  always_comb begin
    a_nib = 4'd0;
    b_nib = 4'd0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_q == IDXW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  csa4 u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .s    (s_nib),
    .cout (c_nib)
  );

  // Datapath: operand latch, nibble write-back, carry chain, RR pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      ovf_q   <= 1'b0;
      prio_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= sel_a;
            b_q     <= sel_sub ? ~sel_b : sel_b;
            carry_q <= sel_sub;
            id_q    <= grant;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDXW'(i)) begin
              sum_q[4*i +: 4] <= s_nib;
            end
          end
          carry_q <= c_nib;
          idx_q   <= idx_q + IDXW'(1);
          // Signed overflow is judged on the top nibble as it is produced.
          if (last_nib) begin
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_nib[3] != a_q[WIDTH-1]);
          end
        end
        DONE: begin
          if (res_ready) begin
            prio_q <= ~id_q;
          end
        end
        default: begin
          idx_q <= '0;
        end
      endcase
    end
  end

  assign res_sum  = sum_q;
  assign res_cout = carry_q;
  assign res_ovf  = ovf_q;
  assign res_id   = id_q;

endmodule

// File: tb/tb_csa_share_sched.sv
// Bench for csa_share_sched: directed vectors, round-robin, hold and reset
// corner cases, plus randomized traffic against an arithmetic reference model.

module tb_csa_share_sched;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_sub;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_sub;
  logic [W-1:0] req1_a, req1_b;
  logic         res_valid, res_ready, res_cout, res_ovf, res_id, busy;
  logic [W-1:0] res_sum;
  logic [1:0]   fsm_state;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic         prio_m = 1'b0;
  logic [W+2:0] exp_q[$];

  csa_share_sched #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sub   (req0_sub),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sub   (req1_sub),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_ovf    (res_ovf),
    .res_id     (res_id),
    .busy       (busy),
    .fsm_state  (fsm_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Reference: plain integer arithmetic, result packed {id, ovf, cout, sum}
  function automatic logic [W+2:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub, input logic id);
    int   sa, sb, sr;
    int   ua, ub, ur;
    logic cout, ovf;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    sr = sub ? sa - sb : sa + sb;
    ur = sub ? ua - ub : ua + ub;
    ovf  = (sr > 32767) || (sr < -32768);
    cout = sub ? (ua >= ub) : (ur >= 65536);
    return {id, ovf, cout, W'(ur)};
  endfunction

  task automatic apply_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    prio_m = 1'b0;
    exp_q.delete();
  endtask

  // Driver: one full operation; pushes the expectation, returns observations
  task automatic drive_op(input logic v0, input logic v1,
                          input logic [W-1:0] a0, input logic [W-1:0] b0, input logic s0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input logic s1,
                          input int hold, input bit keep,
                          output logic [1:0] rdy, output int lat, output int viol,
                          output logic [W+2:0] got, output logic post);
    logic gid;
    @(negedge clk);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
    res_ready  = 1'b0;
    gid = (v0 && v1) ? prio_m : v1;
    exp_q.push_back(gid ? model_op(a1, b1, s1, 1'b1) : model_op(a0, b0, s0, 1'b0));
    #1 rdy = {req1_ready, req0_ready};
    @(posedge clk);
    #1;
    if (!keep) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    req0_a = W'($urandom); req0_b = W'($urandom); req0_sub = 1'($urandom_range(0, 1));
    req1_a = W'($urandom); req1_b = W'($urandom); req1_sub = 1'($urandom_range(0, 1));
    lat  = -1;
    viol = 0;
    for (int k = 1; k <= 4 * NIB && lat < 0; k++) begin
      @(posedge clk);
      #1;
      if (req0_ready || req1_ready) viol++;
      if (res_valid) lat = k;
    end
    got = {res_id, res_ovf, res_cout, res_sum};
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      if (!res_valid || req0_ready || req1_ready ||
          ({res_id, res_ovf, res_cout, res_sum} !== got)) viol++;
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    post      = busy || res_valid;
    res_ready = 1'b0;
    prio_m    = ~gid;
  endtask

  task automatic test_reset();
    apply_reset();
    @(posedge clk);
    #1;
    n_cmp++; if (res_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", res_valid); end
    n_cmp++; if (res_sum !== '0) begin n_bad++; $display("FAIL reset_sum: got %h expected 0000", res_sum); end
    n_cmp++; if ({res_id, res_ovf, res_cout} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", {res_id, res_ovf, res_cout}); end
    n_cmp++; if ({req1_ready, req0_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b expected 00", {req1_ready, req0_ready}); end
    n_cmp++; if (busy !== 1'b0 || fsm_state !== 2'd0) begin n_bad++; $display("FAIL reset_busy: got %b/%0d expected 0/0", busy, fsm_state); end
  endtask

  task automatic test_directed();
    logic [W-1:0] da[3] = '{16'h1234, 16'hFFFF, 16'h8000};
    logic [W-1:0] db[3] = '{16'h4321, 16'h0001, 16'h0001};
    logic [W-1:0] dsum[3] = '{16'h5555, 16'h0000, 16'h7FFF};
    logic         ds[3] = '{1'b0, 1'b0, 1'b1};
    logic         dr[3] = '{1'b0, 1'b0, 1'b1};
    logic         dco[3] = '{1'b0, 1'b1, 1'b1};
    logic         dov[3] = '{1'b0, 1'b0, 1'b1};
    logic [1:0]   rdy;
    int           lat, viol;
    logic [W+2:0] got, exp;
    logic         post;
    for (int i = 0; i < 3; i++) begin
      drive_op(!dr[i], dr[i], da[i], db[i], ds[i], da[i], db[i], ds[i], 0, 1'b0,
               rdy, lat, viol, got, post);
      exp = exp_q.pop_front();
      n_cmp++; if (got !== {dr[i], dov[i], dco[i], dsum[i]}) begin n_bad++; $display("FAIL directed_%0d: got %h expected %h", i, got, {dr[i], dov[i], dco[i], dsum[i]}); end
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL directed_model_%0d: got %h expected %h", i, got, exp); end
      n_cmp++; if (lat != NIB) begin n_bad++; $display("FAIL directed_latency_%0d: got %0d expected %0d", i, lat, NIB); end
      n_cmp++; if (rdy !== (dr[i] ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL directed_ready_%0d: got %b expected %b", i, rdy, dr[i] ? 2'b10 : 2'b01); end
      n_cmp++; if (viol != 0 || post !== 1'b0) begin n_bad++; $display("FAIL directed_proto_%0d: got viol=%0d post=%b expected 0/0", i, viol, post); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]   rdy;
    int           lat, viol;
    logic [W+2:0] got, exp;
    logic         post;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_op(1'b1, 1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
               W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 0, 1'b1,
               rdy, lat, viol, got, post);
      exp = exp_q.pop_front();
      n_cmp++; if (rdy !== ((i % 2) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_grant_%0d: got %b expected %b", i, rdy, (i % 2) ? 2'b10 : 2'b01); end
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rr_result_%0d: got %h expected %h", i, got, exp); end
      n_cmp++; if (lat != NIB || viol != 0) begin n_bad++; $display("FAIL rr_timing_%0d: got lat=%0d viol=%0d expected %0d/0", i, lat, viol, NIB); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_hold();
    logic [1:0]   rdy;
    int           lat, viol;
    logic [W+2:0] got, exp;
    logic         post;
    drive_op(1'b1, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 16'h0000, 16'h8000, 1'b1, 5, 1'b1,
             rdy, lat, viol, got, post);
    exp = exp_q.pop_front();
    n_cmp++; if (viol != 0) begin n_bad++; $display("FAIL hold_stable: got %0d violations expected 0", viol); end
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL hold_result: got %h expected %h", got, exp); end
    n_cmp++; if (post !== 1'b0) begin n_bad++; $display("FAIL hold_release: got %b expected 0", post); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int           seen;
    logic [1:0]   rdy;
    int           lat, viol;
    logic [W+2:0] got, exp;
    logic         post;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 16'hABCD; req0_b = 16'h1111; req0_sub = 1'b0;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL midrun_busy: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({res_valid, busy, res_sum} !== '0) begin n_bad++; $display("FAIL midrun_clear: got %b/%b/%h expected 0/0/0000", res_valid, busy, res_sum); end
    @(negedge clk);
    rst_n  = 1'b1;
    prio_m = 1'b0;
    seen   = 0;
    for (int k = 0; k < NIB + 3; k++) begin
      @(posedge clk);
      #1;
      if (res_valid || busy) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midrun_no_result: got %0d busy cycles expected 0", seen); end
    drive_op(1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0003, 16'h0005, 1'b1, 0, 1'b0,
             rdy, lat, viol, got, post);
    exp = exp_q.pop_front();
    n_cmp++; if (got !== exp || lat != NIB) begin n_bad++; $display("FAIL midrun_recover: got %h lat=%0d expected %h lat=%0d", got, lat, exp, NIB); end
  endtask

  task automatic test_random();
    logic [1:0]   rdy, erdy, sel;
    int           lat, viol, hold;
    logic [W+2:0] got, exp;
    logic         post;
    logic [W-1:0] edge_v[4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [W-1:0] a0, b0, a1, b1;
    for (int i = 0; i < 30; i++) begin
      sel  = 2'($urandom_range(1, 3));
      hold = $urandom_range(0, 3);
      a0 = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : W'($urandom);
      b0 = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : W'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : W'($urandom);
      b1 = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : W'($urandom);
      erdy = (sel == 2'b11) ? (prio_m ? 2'b10 : 2'b01) : sel;
      drive_op(sel[0], sel[1], a0, b0, 1'($urandom_range(0, 1)), a1, b1, 1'($urandom_range(0, 1)),
               hold, 1'($urandom_range(0, 1)), rdy, lat, viol, got, post);
      exp = exp_q.pop_front();
      n_cmp++; if (rdy !== erdy) begin n_bad++; $display("FAIL rand_grant_%0d: got %b expected %b", i, rdy, erdy); end
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rand_result_%0d: got %h expected %h", i, got, exp); end
      n_cmp++; if (lat != NIB || viol != 0 || post !== 1'b0) begin n_bad++; $display("FAIL rand_proto_%0d: got lat=%0d viol=%0d post=%b expected %0d/0/0", i, lat, viol, post, NIB); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_hold();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
